pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Regenerates a level waveform from single-cycle event pulses. This is the inverse of the edge/pulse detector: each accepted trigger pulse produces an output level held high for a programmable number of cycles, followed by an optional programmable holdoff window. It sits downstream of edge-detect and event logic, driving strobes, LEDs, enables and handshake levels that need a minimum width.

## Interface
- CNT_W, 8, width of the `width` and `holdoff` inputs and of the internal down-counter.
- DROP_W, 8, width of the saturating dropped-trigger counter.

- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- trig  input  1  event pulse, sampled every rising edge; a multi-cycle high counts as one trigger per cycle.
- width  input  CNT_W  output high time in cycles, latched on each accepted trigger; 0 is treated as 1.
- holdoff  input  CNT_W  dead time after the output falls, latched when the output falls; 0 means no holdoff.
- drop_clr  input  1  clears `drop_cnt`.
- pulse_out  output  1  stretched level, registered.
- busy  output  1  high in HIGH and HOLDOFF, registered.
- done  output  1  one-cycle strobe on the cycle the output falls, registered.
- drop_cnt  output  DROP_W  saturating count of ignored triggers.

## Operation
- States:
  - IDLE: outputs low.
  - HIGH: `pulse_out`=1.
  - HOLDOFF: `pulse_out`=0, `busy`=1.
- Reset behaviour: state IDLE, counter 0, and all outputs 0 on the edge where `rst`=1. Reset mid-pulse drops `pulse_out` after that edge, with no `done`.
- IDLE with `trig`=1: go to HIGH and load the counter with max(`width`,1)−1.
- HIGH with counter ≠ 0: decrement the counter.
- HIGH with counter = 0 (and no retrigger): `pulse_out` goes to 0 and `done` pulses for one cycle.
  - If `holdoff`≠0: go to HOLDOFF and load the counter with `holdoff`−1.
  - If `holdoff`=0: go to IDLE.
- HOLDOFF with counter = 0: go to IDLE. Otherwise decrement the counter.
- Dropped triggers:
  - Any `trig` sampled in HOLDOFF increments `drop_cnt`.
  - Any `trig` sampled in HIGH increments `drop_cnt` when retrigger is compiled out.
- `drop_cnt` saturates at 2^DROP_W−1 and never wraps.
- Simultaneous `drop_clr` and a dropped trigger: `drop_cnt` becomes 1.
- `width` and `holdoff` may change at any time. Only the values at the latch points matter.

## Timing
- A trigger sampled at edge k sets `pulse_out` high after edge k.
- `pulse_out` stays high for exactly max(W,1) cycles and falls after edge k+max(W,1).
- `done` is high for the one cycle following the falling edge of `pulse_out`.
- With holdoff H, the output falls at edge e. Triggers sampled at edges e+1…e+H are dropped. A trigger at edge e+H+1 is accepted.
- With H=0, a trigger at edge e+1 is accepted, giving a minimum of one low cycle between pulses.
- A trigger at edge e itself (final HIGH cycle) falls under the HIGH rules.

## Configuration
- RETRIGGER_EN
  - Defined: `trig` sampled in HIGH, including the final HIGH cycle, reloads the counter with max(`width`,1)−1 from the current `width`. `pulse_out` stays high, there is no `done`, and `drop_cnt` is unchanged.
  - Undefined: `trig` in HIGH is ignored and counted in `drop_cnt`.

## Test plan
- Basic pulse: reset, then width=5, holdoff=0, one-cycle trig at edge 10 → `pulse_out` high after edges 10–14, low after edge 15, `done` high one cycle after edge 15, `drop_cnt`=0.
- Width 0 and 1: width=0, trig → 1-cycle high. width=1 gives an identical waveform.
- Holdoff: width=3, holdoff=4, trig at edge 0, trig again at edges 4 and 7 → both dropped, `drop_cnt`=2. A trig at edge 8 is accepted and `busy` covers edges 0–7.
- Retrigger, macro defined: width=4, trig at edges 0 and 2 → `pulse_out` high for 6 cycles, one `done`.
- Retrigger, macro undefined: same stimulus → 4-cycle high, `drop_cnt`=1.
- Saturation and clear:
  - DROP_W=2 with 5 dropped triggers → `drop_cnt`=3.
  - `drop_clr` coincident with a drop → 1.
- Reset mid-operation: `rst` at the second cycle of a width=10 pulse → outputs 0 after that edge, no `done`. The next trig produces a full 10-cycle pulse.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle trigger pulses into a level of programmable width,
// followed by an optional holdoff window. Define RETRIGGER_EN to let triggers during HIGH extend the pulse.
module pulse_stretcher #(
  parameter int CNT_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic              drop_clr,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   width_m1;
  logic               drop_evt;

  // A programmed width of 0 behaves exactly like a width of 1.
  assign width_m1 = (width == '0) ? '0 : width - CNT_W'(1);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    drop_evt = 1'b0;
    if (trig) begin
      if (state == HOLDOFF)            drop_evt = 1'b1;
      else if (state == HIGH && !RETRIG) drop_evt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            state     <= HIGH;
            cnt       <= width_m1;
            pulse_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (RETRIG && trig) begin
            cnt <= width_m1;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Holdoff is latched here, at the falling edge of the output.
            pulse_out <= 1'b0;
            done      <= 1'b1;
            if (holdoff != '0) begin
              state <= HOLDOFF;
              cnt   <= holdoff - CNT_W'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HOLDOFF: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of ignored triggers; a clear coinciding with a drop leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= drop_evt ? DROP_W'(1) : '0;
    end else if (drop_evt && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: vector table, directed corner cases,
// and random stimulus against a timestamp-based reference model.
module tb_pulse_stretcher;

`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, trig, drop_clr;
  logic [7:0] width, holdoff;
  logic       pulse_out, busy, done;
  logic [7:0] drop_cnt;
  logic       pulse_out2, busy2, done2;
  logic [1:0] drop_cnt2;

  always #5 clk = ~clk;

  pulse_stretcher #(.CNT_W(8), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .trig(trig), .width(width), .holdoff(holdoff),
    .drop_clr(drop_clr), .pulse_out(pulse_out), .busy(busy), .done(done),
    .drop_cnt(drop_cnt)
  );

  pulse_stretcher #(.CNT_W(8), .DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .trig(trig), .width(width), .holdoff(holdoff),
    .drop_clr(drop_clr), .pulse_out(pulse_out2), .busy(busy2), .done(done2),
    .drop_cnt(drop_cnt2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  // Reference model: pulse timing kept as absolute edge timestamps.
  int t_edge     = 0;
  bit m_hi       = 1'b0;
  int m_fall     = 0;
  int m_hold_end = -1;
  int m_drop     = 0;
  bit m_pulse, m_busy, m_done;

  task automatic model_edge(input int r, input int tg, input int w, input int h, input int c);
    bit dropped = 1'b0;
    int wid = (w == 0) ? 1 : w;
    m_done = 1'b0;
    if (r != 0) begin
      m_hi       = 1'b0;
      m_hold_end = -1;
      m_drop     = 0;
    end else begin
      if (m_hi) begin
        if (tg != 0) begin
          if (RETRIG) m_fall = t_edge + wid;
          else        dropped = 1'b1;
        end
        if (t_edge == m_fall) begin
          m_hi       = 1'b0;
          m_done     = 1'b1;
          m_hold_end = t_edge + h;
        end
      end else if (t_edge <= m_hold_end) begin
        if (tg != 0) dropped = 1'b1;
      end else if (tg != 0) begin
        m_hi   = 1'b1;
        m_fall = t_edge + wid;
      end
      if (c != 0)       m_drop = dropped ? 1 : 0;
      else if (dropped) m_drop++;
    end
    m_pulse = m_hi;
    m_busy  = m_hi || (t_edge < m_hold_end);
    t_edge++;
  endtask

  task automatic step(input int r, input int tg, input int w, input int h, input int c);
    rst      = (r != 0);
    trig     = (tg != 0);
    width    = 8'(w);
    holdoff  = 8'(h);
    drop_clr = (c != 0);
    @(posedge clk);
    model_edge(r, tg, w, h, c);
    #1;
    check("model_pulse",  32'(pulse_out),  32'(m_pulse));
    check("model_busy",   32'(busy),       32'(m_busy));
    check("model_done",   32'(done),       32'(m_done));
    check("model_drop8",  32'(drop_cnt),   32'(sat(m_drop, 255)));
    check("model_pulse2", 32'(pulse_out2), 32'(m_pulse));
    check("model_drop2",  32'(drop_cnt2),  32'(sat(m_drop, 3)));
  endtask

  typedef struct {
    int r, t, w, h, c;
    int p, b, d, dc;
  } vec_t;

  function automatic vec_t mk(input int r, input int t, input int w, input int h, input int c,
                              input int p, input int b, input int d, input int dc);
    vec_t v;
    v.r = r; v.t = t; v.w = w; v.h = h; v.c = c;
    v.p = p; v.b = b; v.d = d; v.dc = dc;
    return v;
  endfunction

  initial begin
    vec_t vt[$];
    int hi, dn, bz, fall_at;

    rst = 1'b1; trig = 1'b0; width = '0; holdoff = '0; drop_clr = 1'b0;

    // Vector table: inputs for one edge, outputs expected after that edge.
    vt.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0));
    vt.push_back(mk(0, 1, 3, 7, 0,  1, 1, 0, 0));
    vt.push_back(mk(0, 0, 9, 7, 0,  1, 1, 0, 0));
    vt.push_back(mk(0, 0, 9, 7, 0,  1, 1, 0, 0));
    vt.push_back(mk(0, 0, 9, 2, 0,  0, 1, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 1));
    vt.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 2));
    vt.push_back(mk(0, 1, 0, 5, 0,  1, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 2));
    vt.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].t, vt[i].w, vt[i].h, vt[i].c);
      check($sformatf("vec%0d_pulse", i), 32'(pulse_out), 32'(vt[i].p));
      check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vt[i].b));
      check($sformatf("vec%0d_done", i),  32'(done),      32'(vt[i].d));
      check($sformatf("vec%0d_drop", i),  32'(drop_cnt),  32'(vt[i].dc));
    end

    // Basic pulse: width 5, trigger at edge 10 after reset.
    step(1, 0, 0, 0, 0);
    repeat (9) step(0, 0, 5, 0, 0);
    step(0, 1, 5, 0, 0);
    hi = int'(pulse_out); dn = 0; fall_at = -1;
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 5, 0, 0);
      hi += int'(pulse_out);
      dn += int'(done);
      if (done && fall_at < 0) fall_at = i;
    end
    check("basic_high_cycles", 32'(hi), 32'd5);
    check("basic_done_count",  32'(dn), 32'd1);
    check("basic_fall_edge",   32'(fall_at), 32'd5);
    check("basic_drop",        32'(drop_cnt), 32'd0);

    // Retrigger: width 4, triggers at relative edges 0 and 2.
    step(1, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0);
    hi = int'(pulse_out); dn = int'(done);
    step(0, 0, 4, 0, 0); hi += int'(pulse_out); dn += int'(done);
    step(0, 1, 4, 0, 0); hi += int'(pulse_out); dn += int'(done);
    repeat (8) begin
      step(0, 0, 4, 0, 0);
      hi += int'(pulse_out);
      dn += int'(done);
    end
    check("retrig_high_cycles", 32'(hi), RETRIG ? 32'd6 : 32'd4);
    check("retrig_done_count",  32'(dn), 32'd1);
    check("retrig_drop",        32'(drop_cnt), RETRIG ? 32'd0 : 32'd1);

    // Holdoff: width 3, holdoff 4; triggers at 4 and 7 dropped, 8 accepted.
    step(1, 0, 0, 0, 0);
    step(0, 1, 3, 4, 0);
    bz = int'(busy);
    for (int e = 1; e <= 7; e++) begin
      step(0, (e == 4 || e == 7) ? 1 : 0, 3, 4, 0);
      if (e <= 6) bz += int'(busy);
    end
    check("holdoff_busy_cycles", 32'(bz), 32'd7);
    check("holdoff_busy_edge7",  32'(busy), 32'd0);
    check("holdoff_drop",        32'(drop_cnt), 32'd2);
    step(0, 1, 3, 4, 0);
    check("holdoff_accept_edge8", 32'(pulse_out), 32'd1);
    repeat (8) step(0, 0, 3, 0, 0);

    // Reset mid-pulse, then a full 10-cycle pulse.
    step(1, 0, 0, 0, 0);
    step(0, 1, 10, 0, 0);
    step(0, 0, 10, 0, 0);
    step(1, 0, 10, 0, 0);
    check("midrst_pulse", 32'(pulse_out), 32'd0);
    check("midrst_busy",  32'(busy),      32'd0);
    check("midrst_done",  32'(done),      32'd0);
    step(0, 1, 10, 0, 0);
    hi = int'(pulse_out); dn = 0;
    repeat (12) begin
      step(0, 0, 10, 0, 0);
      hi += int'(pulse_out);
      dn += int'(done);
    end
    check("midrst_full_high", 32'(hi), 32'd10);
    check("midrst_full_done", 32'(dn), 32'd1);

    // Saturation on the 2-bit counter, then clear coincident with a drop.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 8, 0);
    step(0, 0, 1, 8, 0);
    repeat (5) step(0, 1, 1, 8, 0);
    check("sat_drop2", 32'(drop_cnt2), 32'd3);
    check("sat_drop8", 32'(drop_cnt),  32'd5);
    step(0, 1, 1, 8, 1);
    check("clr_drop2", 32'(drop_cnt2), 32'd1);
    check("clr_drop8", 32'(drop_cnt),  32'd1);
    repeat (6) step(0, 0, 1, 0, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1 : 0,
           ($urandom_range(0, 9) < 3) ? 1 : 0,
           int'($urandom_range(0, 6)),
           int'($urandom_range(0, 5)),
           ($urandom_range(0, 39) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
